// File: rtl/gen_demux_if.sv
`default_nettype none
// ============================================================================
//  Module      : gen_demux_if
//  Description : Bundle for the gen_demux stream demultiplexer. It carries one
//                valid/ready input stream (with lane select) and OUTPUTS_NUM
//                valid/ready output lanes, plus the dropped-beat error pulse.
//                  in_data/in_valid/in_sel : upstream beat and destination
//                  in_ready                : demux accepts the beat this cycle
//                  out_data/out_valid      : per-lane beat held for consumers
//                  out_ready               : per-lane consumer ready
//                  err_sel                 : one-cycle pulse, bad select dropped
//                Modport slave is the demux side, master the environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gen_demux_if #(
    parameter int DATA_WIDTH  = 1,
    parameter int OUTPUTS_NUM = 3
);
    localparam int SELECT_WIDTH = $clog2(OUTPUTS_NUM);

    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic [SELECT_WIDTH-1:0] in_sel;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   out_data [0:OUTPUTS_NUM-1];
    logic [OUTPUTS_NUM-1:0]  out_valid;
    logic [OUTPUTS_NUM-1:0]  out_ready;
    logic                    err_sel;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_sel,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output err_sel
    );

    modport master (
        output in_data,
        output in_valid,
        output in_sel,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  err_sel
    );
endinterface
`default_nettype wire

// File: rtl/gen_demux.sv
`default_nettype none
// ============================================================================
//  Module      : gen_demux
//  Description : Stream demultiplexer. Each accepted input beat is steered to
//                one of OUTPUTS_NUM lanes, each lane holding one beat in a
//                register until its consumer takes it. A lane that is drained
//                and reloaded in the same cycle stays valid (no bubble).
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus        - gen_demux_if.slave: input stream with select,
//                             per-lane outputs, err_sel pulse
//  Config      : GEN_DEMUX_RR_EN - when defined, in_sel is ignored and beats
//                are dealt to lanes in strict round-robin order from an
//                internal pointer; err_sel is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_demux #(
    parameter int DATA_WIDTH  = 1,
    parameter int OUTPUTS_NUM = 3
) (
    input  wire logic  clk,
    input  wire logic  rst,
    gen_demux_if.slave bus
);
    localparam int SELECT_WIDTH = $clog2(OUTPUTS_NUM);

    logic [SELECT_WIDTH-1:0] w_dest;
    logic [OUTPUTS_NUM-1:0]  w_hit;
    logic [OUTPUTS_NUM-1:0]  w_lane_free;
    logic                    w_in_range;
    logic                    w_dest_free;
    logic                    w_ready;
    logic                    w_accept;

    logic [OUTPUTS_NUM-1:0]  r_valid;
    logic [DATA_WIDTH-1:0]   r_data [0:OUTPUTS_NUM-1];

`ifdef GEN_DEMUX_RR_EN
    // Round-robin: destination comes from the pointer; the select input is
    // deliberately left unconnected to any logic.
    logic [SELECT_WIDTH-1:0] r_rr_ptr;
    logic [SELECT_WIDTH-1:0] w_unused_sel;

    assign w_unused_sel = bus.in_sel;
    assign w_dest       = r_rr_ptr;

    // Strict order: the pointer only moves on an accept, so a busy lane
    // stalls the stream rather than being skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            if (r_rr_ptr == SELECT_WIDTH'(OUTPUTS_NUM - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= r_rr_ptr + 1'b1;
            end
        end
    end

    assign bus.err_sel = 1'b0;
`else
    logic r_err_sel;

    assign w_dest = bus.in_sel;

    // Pulses only for the cycle after each dropped out-of-range beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sel <= 1'b0;
        end else begin
            r_err_sel <= w_accept & ~w_in_range;
        end
    end

    assign bus.err_sel = r_err_sel;
`endif

    // One-hot decode of the destination. An out-of-range select matches no
    // lane, which is how the drop path is detected without a magnitude compare.
    for (genvar g = 0; g < OUTPUTS_NUM; g++) begin : g_lane
        assign w_hit[g]        = (w_dest == SELECT_WIDTH'(g));
        assign w_lane_free[g]  = ~r_valid[g] | bus.out_ready[g];
        assign bus.out_data[g] = r_data[g];
    end

    assign w_in_range  = |w_hit;
    assign w_dest_free = |(w_hit & w_lane_free);

    // in_valid deliberately does not feed in_ready. Out-of-range beats are
    // always taken so a bad select cannot wedge the stream.
    assign w_ready  = ~rst & (w_in_range ? w_dest_free : 1'b1);
    assign w_accept = bus.in_valid & w_ready;

    // Load has priority over drain so a same-cycle drain+load keeps the lane
    // valid with the new beat. Data is not cleared on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < OUTPUTS_NUM; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < OUTPUTS_NUM; k++) begin
                if (w_accept && w_hit[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_gen_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_demux
//  Description : Directed bench for gen_demux (DATA_WIDTH=8, OUTPUTS_NUM=3).
//                A table of {inputs, expected outputs} is applied one beat
//                per cycle, followed by reset checks. The table contents
//                follow GEN_DEMUX_RR_EN so both builds are covered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_demux;
    localparam int DW = 8;
    localparam int NO = 3;
    localparam int NV = 16;

    typedef struct {
        logic          valid;
        logic [1:0]    sel;
        logic [DW-1:0] data;
        logic [2:0]    ordy;
        logic          rdy;
        logic [2:0]    ov;
        logic          err;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs [NV];

    gen_demux_if #(.DATA_WIDTH(DW), .OUTPUTS_NUM(NO)) bus ();

    gen_demux #(.DATA_WIDTH(DW), .OUTPUTS_NUM(NO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A stalled beat must hold its data and select until accepted.
    logic          p_stall;
    logic [DW-1:0] p_data;
    logic [1:0]    p_sel;
    initial p_stall = 1'b0;
    always @(posedge clk) begin
        if (p_stall && !rst) begin
            assert (bus.in_data == p_data && bus.in_sel == p_sel)
                else $error("stalled beat changed");
        end
        p_stall <= bus.in_valid && !bus.in_ready && !rst;
        p_data  <= bus.in_data;
        p_sel   <= bus.in_sel;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chk_lanes(input string tag, input logic [2:0] ov, input logic err,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".err_sel"},   32'(bus.err_sel),   32'(err));
        chk({tag, ".out_data0"}, 32'(bus.out_data[0]), 32'(d0));
        chk({tag, ".out_data1"}, 32'(bus.out_data[1]), 32'(d1));
        chk({tag, ".out_data2"}, 32'(bus.out_data[2]), 32'(d2));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

`ifdef GEN_DEMUX_RR_EN
        // Round-robin: sel fixed at 0, beats dealt 0,1,2,0,...; lane 1 blocked
        // in R10/R11 stalls the stream and lane 2 stays untouched.
        vecs[0]  = '{1'b1, 2'd0, 8'hD0, 3'b111, 1'b1, 3'b001, 1'b0, 8'hD0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 2'd0, 8'hD1, 3'b111, 1'b1, 3'b010, 1'b0, 8'hD0, 8'hD1, 8'h00};
        vecs[2]  = '{1'b1, 2'd0, 8'hD2, 3'b111, 1'b1, 3'b100, 1'b0, 8'hD0, 8'hD1, 8'hD2};
        vecs[3]  = '{1'b1, 2'd0, 8'hD3, 3'b111, 1'b1, 3'b001, 1'b0, 8'hD3, 8'hD1, 8'hD2};
        vecs[4]  = '{1'b1, 2'd0, 8'hE0, 3'b111, 1'b1, 3'b010, 1'b0, 8'hD3, 8'hE0, 8'hD2};
        vecs[5]  = '{1'b1, 2'd0, 8'hE1, 3'b111, 1'b1, 3'b100, 1'b0, 8'hD3, 8'hE0, 8'hE1};
        vecs[6]  = '{1'b1, 2'd0, 8'hE2, 3'b101, 1'b1, 3'b001, 1'b0, 8'hE2, 8'hE0, 8'hE1};
        vecs[7]  = '{1'b1, 2'd0, 8'hF0, 3'b101, 1'b1, 3'b010, 1'b0, 8'hE2, 8'hF0, 8'hE1};
        vecs[8]  = '{1'b1, 2'd0, 8'hF1, 3'b101, 1'b1, 3'b110, 1'b0, 8'hE2, 8'hF0, 8'hF1};
        vecs[9]  = '{1'b1, 2'd0, 8'hF2, 3'b101, 1'b1, 3'b011, 1'b0, 8'hF2, 8'hF0, 8'hF1};
        vecs[10] = '{1'b1, 2'd0, 8'hF3, 3'b101, 1'b0, 3'b010, 1'b0, 8'hF2, 8'hF0, 8'hF1};
        vecs[11] = '{1'b1, 2'd0, 8'hF3, 3'b101, 1'b0, 3'b010, 1'b0, 8'hF2, 8'hF0, 8'hF1};
        vecs[12] = '{1'b1, 2'd0, 8'hF3, 3'b111, 1'b1, 3'b010, 1'b0, 8'hF2, 8'hF3, 8'hF1};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 1'b0, 8'hF2, 8'hF3, 8'hF1};
        vecs[14] = '{1'b1, 2'd0, 8'h60, 3'b000, 1'b1, 3'b100, 1'b0, 8'hF2, 8'hF3, 8'h60};
        vecs[15] = '{1'b1, 2'd0, 8'h61, 3'b000, 1'b1, 3'b101, 1'b0, 8'h61, 8'hF3, 8'h60};
`else
        // Steering, backpressure with zero-bubble reload, invalid selects.
        vecs[0]  = '{1'b1, 2'd0, 8'hA1, 3'b111, 1'b1, 3'b001, 1'b0, 8'hA1, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 2'd2, 8'hB2, 3'b111, 1'b1, 3'b100, 1'b0, 8'hA1, 8'h00, 8'hB2};
        vecs[2]  = '{1'b1, 2'd1, 8'hC3, 3'b111, 1'b1, 3'b010, 1'b0, 8'hA1, 8'hC3, 8'hB2};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 1'b0, 8'hA1, 8'hC3, 8'hB2};
        vecs[4]  = '{1'b1, 2'd1, 8'h11, 3'b101, 1'b1, 3'b010, 1'b0, 8'hA1, 8'h11, 8'hB2};
        vecs[5]  = '{1'b1, 2'd1, 8'h22, 3'b101, 1'b0, 3'b010, 1'b0, 8'hA1, 8'h11, 8'hB2};
        vecs[6]  = '{1'b1, 2'd1, 8'h22, 3'b101, 1'b0, 3'b010, 1'b0, 8'hA1, 8'h11, 8'hB2};
        vecs[7]  = '{1'b1, 2'd1, 8'h22, 3'b111, 1'b1, 3'b010, 1'b0, 8'hA1, 8'h22, 8'hB2};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 1'b0, 8'hA1, 8'h22, 8'hB2};
        vecs[9]  = '{1'b1, 2'd3, 8'h55, 3'b111, 1'b1, 3'b000, 1'b1, 8'hA1, 8'h22, 8'hB2};
        vecs[10] = '{1'b0, 2'd3, 8'h00, 3'b111, 1'b1, 3'b000, 1'b0, 8'hA1, 8'h22, 8'hB2};
        vecs[11] = '{1'b1, 2'd0, 8'h66, 3'b000, 1'b1, 3'b001, 1'b0, 8'h66, 8'h22, 8'hB2};
        vecs[12] = '{1'b1, 2'd3, 8'h77, 3'b000, 1'b1, 3'b001, 1'b1, 8'h66, 8'h22, 8'hB2};
        vecs[13] = '{1'b1, 2'd3, 8'h78, 3'b000, 1'b1, 3'b001, 1'b1, 8'h66, 8'h22, 8'hB2};
        vecs[14] = '{1'b0, 2'd0, 8'h00, 3'b000, 1'b0, 3'b001, 1'b0, 8'h66, 8'h22, 8'hB2};
        vecs[15] = '{1'b1, 2'd2, 8'h88, 3'b000, 1'b1, 3'b101, 1'b0, 8'h66, 8'h22, 8'h88};
`endif

        // Reset held 3 cycles with a beat offered: nothing accepted.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'hFF;
        bus.out_ready = 3'b111;
        #1;
        chk("reset.in_ready_pre", 32'(bus.in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reset%0d.in_ready", c), 32'(bus.in_ready), 32'd0);
            chk_lanes($sformatf("reset%0d", c), 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
        end
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.in_valid  = vecs[i].valid;
            bus.in_sel    = vecs[i].sel;
            bus.in_data   = vecs[i].data;
            bus.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk_lanes($sformatf("vec%0d", i), vecs[i].ov, vecs[i].err,
                      vecs[i].d0, vecs[i].d1, vecs[i].d2);
        end

        // Mid-operation reset with lanes 0 and 2 holding beats.
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 3'b000;
        #1;
        chk("midrst.in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_lanes("midrst", 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);

        // First beat right after reset release is accepted.
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'h99;
        #1;
        chk("postrst.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
`ifdef GEN_DEMUX_RR_EN
        chk_lanes("postrst", 3'b001, 1'b0, 8'h99, 8'h00, 8'h00);
`else
        chk_lanes("postrst", 3'b100, 1'b0, 8'h00, 8'h00, 8'h99);
`endif
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
